// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scanner.
package seg_pkg;

  localparam int unsigned SCAN_DIV_DEF     = 100000;
  localparam int unsigned GUARD_DEF        = 16;
  localparam int unsigned BLINK_FRAMES_DEF = 125;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; entry 0 sits in the least significant slot.
  localparam logic [15:0][6:0] GLYPHS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic [3:0]  blink_mask;
    logic        lz_blank;
  } snap_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit value to active-low 7-segment glyph.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = GLYPHS[value];
  end

endmodule

// File: rtl/seg_scan_display.sv
// Four-digit multiplexed 7-segment driver with frame snapshot, guard band,
// leading-zero blanking and per-digit blink.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = SCAN_DIV_DEF,
  parameter int unsigned GUARD        = GUARD_DEF,
  parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blink_mask,
  input  logic        lz_blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIV_W-1:0] div_q;
  logic [1:0]       slot_q;
  logic [FC_W-1:0]  frame_q;
  logic             blink_phase_q;
  snap_t            snap_q;

  logic             div_wrap_c;
  logic             frame_wrap_c;
  logic [3:0]       lz_c;
  logic [3:0]       blank_c;
  logic [3:0]       cur_digit_c;
  logic [6:0]       glyph_c;
  logic             guard_c;
  logic             shown_c;

  assign div_wrap_c   = (div_q == DIV_W'(SCAN_DIV - 1));
  assign frame_wrap_c = div_wrap_c && (slot_q == 2'd3);

  // Scan divider, slot, frame/blink counters and the per-frame input snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      slot_q        <= '0;
      frame_q       <= '0;
      blink_phase_q <= 1'b0;
      snap_q        <= '0;
    end else begin
      div_q <= div_wrap_c ? '0 : div_q + DIV_W'(1);
      if (div_wrap_c) begin
        slot_q <= slot_q + 2'd1;
      end
      if (frame_wrap_c) begin
        snap_q <= '{digits: digits, dp_mask: dp_mask,
                    blink_mask: blink_mask, lz_blank: lz_blank};
        if (frame_q == FC_W'(BLINK_FRAMES - 1)) begin
          frame_q       <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          frame_q <= frame_q + FC_W'(1);
        end
      end
    end
  end

  // A digit is dark when it is a leading zero or in the off half of its blink.
  always_comb begin
    lz_c    = 4'b0000;
    lz_c[3] = (snap_q.digits[15:12] == 4'd0);
    lz_c[2] = lz_c[3] && (snap_q.digits[11:8] == 4'd0);
    lz_c[1] = lz_c[2] && (snap_q.digits[7:4] == 4'd0);
    blank_c = (snap_q.lz_blank ? lz_c : 4'b0000)
            | (blink_phase_q ? snap_q.blink_mask : 4'b0000);
    cur_digit_c = snap_q.digits[{slot_q, 2'b00} +: 4];
    guard_c     = (32'(div_q) < GUARD);
    shown_c     = en && !blank_c[slot_q];
  end

  seg_hex_decode u_decode (
    .value (cur_digit_c),
    .seg_c (glyph_c)
  );

  // Anodes stay off through the guard window; segments keep the slot's glyph.
  always_ff @(posedge clk) begin
    if (rst) begin
      an          <= 4'b1111;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_wrap_c;
      an          <= (shown_c && !guard_c) ? ~(4'b0001 << slot_q) : 4'b1111;
      seg         <= shown_c ? glyph_c : SEG_BLANK;
      dp          <= !(shown_c && snap_q.dp_mask[slot_q]);
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  blink_mask = 4'h0;
  logic        lz_blank = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg_scan_display #(.SCAN_DIV(8), .GUARD(2), .BLINK_FRAMES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .digits      (digits),
    .dp_mask     (dp_mask),
    .blink_mask  (blink_mask),
    .lz_blank    (lz_blank),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  typedef struct {
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dpm;
    logic        lz;
    int          j;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    bit          an_only;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] ea, input logic [6:0] es,
                           input logic ed, input bit an_only);
    check({name, ".an"}, 16'(an), 16'(ea));
    if (!an_only) begin
      check({name, ".seg"}, 16'(seg), 16'(es));
      check({name, ".dp"}, 16'(dp), 16'(ed));
    end
  endtask

  // Bounded wait for the next frame_start pulse; a timeout shows as a failed check.
  task automatic wait_fs(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 40);
    check({name, ".fs_seen"}, 16'(frame_start), 16'd1);
  endtask

  initial begin
    bit fs_early;
    int f;
    int jj;

    vt.push_back(vec_t'{1'b1, 16'h1234, 4'h0, 1'b0,  2, 4'b1110, 7'b0011001, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h1234, 4'h0, 1'b0,  0, 4'b1111, 7'b0000000, 1'b1, 1'b1});
    vt.push_back(vec_t'{1'b1, 16'h1234, 4'h0, 1'b0, 25, 4'b1111, 7'b0000000, 1'b1, 1'b1});
    vt.push_back(vec_t'{1'b1, 16'h1234, 4'h0, 1'b0, 26, 4'b0111, 7'b1111001, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h1234, 4'h0, 1'b0, 31, 4'b0111, 7'b1111001, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h1234, 4'h0, 1'b0, 13, 4'b1101, 7'b0110000, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h1234, 4'h0, 1'b0, 18, 4'b1011, 7'b0100100, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h0005, 4'h2, 1'b1, 10, 4'b1111, 7'b1111111, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h0005, 4'h2, 1'b1,  2, 4'b1110, 7'b0010010, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h0005, 4'h2, 1'b1, 18, 4'b1111, 7'b1111111, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h0005, 4'h2, 1'b1, 26, 4'b1111, 7'b1111111, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h0005, 4'h2, 1'b0, 10, 4'b1101, 7'b1000000, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h0005, 4'h1, 1'b1,  4, 4'b1110, 7'b0010010, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h00A0, 4'h1, 1'b1,  3, 4'b1110, 7'b1000000, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h00A0, 4'h1, 1'b1, 11, 4'b1101, 7'b0001000, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h00A0, 4'h1, 1'b1, 19, 4'b1111, 7'b1111111, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h0B00, 4'h0, 1'b1, 11, 4'b1101, 7'b1000000, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h0B00, 4'h0, 1'b1, 19, 4'b1011, 7'b0000011, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'hCDEF, 4'h0, 1'b0,  2, 4'b1110, 7'b0001110, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'hCDEF, 4'h0, 1'b0, 10, 4'b1101, 7'b0000110, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'hCDEF, 4'h0, 1'b0, 18, 4'b1011, 7'b0100001, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'hCDEF, 4'h0, 1'b0, 26, 4'b0111, 7'b1000110, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h6789, 4'h0, 1'b0,  7, 4'b1110, 7'b0010000, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h6789, 4'h0, 1'b0, 15, 4'b1101, 7'b0000000, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h6789, 4'h0, 1'b0, 23, 4'b1011, 7'b1111000, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h6789, 4'h0, 1'b0, 31, 4'b0111, 7'b0000010, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b0, 16'h1234, 4'hF, 1'b0,  2, 4'b1111, 7'b1111111, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 16'h1234, 4'hF, 1'b0,  2, 4'b1110, 7'b0011001, 1'b0, 1'b0});

    // Power-on reset; the inputs already hold data that must not leak into frame 0.
    rst = 1'b1;
    en = 1'b1;
    digits = 16'h1234;
    repeat (3) @(negedge clk);
    check_out("reset", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    check("reset.fs", 16'(frame_start), 16'd0);
    rst = 1'b0;
    fs_early = 1'b0;
    for (int g = 0; g < 32; g++) begin
      @(negedge clk);
      if (g == 0) check_out("f0.guard", 4'b1111, 7'b0, 1'b1, 1'b1);
      if (g == 2) check_out("f0.zero_snap", 4'b1110, 7'b1000000, 1'b1, 1'b0);
      if (g < 31) fs_early |= frame_start;
      if (g == 31) check("f0.first_fs_at_32", 16'(frame_start), 16'd1);
    end
    check("f0.no_early_fs", 16'(fs_early), 16'd0);

    // One frame per table entry: load inputs, let them be snapshotted, sample slot j.
    foreach (vt[i]) begin
      en = vt[i].en;
      digits = vt[i].digits;
      dp_mask = vt[i].dpm;
      lz_blank = vt[i].lz;
      blink_mask = 4'h0;
      wait_fs($sformatf("v%0d", i));
      repeat (vt[i].j + 1) @(negedge clk);
      check_out($sformatf("v%0d", i), vt[i].an, vt[i].seg, vt[i].dp, vt[i].an_only);
    end

    // Mid-frame input change, en drop/restore, and frame_start pulse width.
    en = 1'b1;
    digits = 16'h1234;
    dp_mask = 4'h0;
    lz_blank = 1'b0;
    wait_fs("snap");
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      if (j == 0) check("snap.fs_one_cycle", 16'(frame_start), 16'd0);
      if (j == 8) check_out("snap.guard1", 4'b1111, 7'b0, 1'b1, 1'b1);
      if (j == 9) digits = 16'h9999;
      if (j == 10) check_out("snap.s1", 4'b1101, 7'b0110000, 1'b1, 1'b0);
      if (j == 12) en = 1'b0;
      if (j == 13) begin
        check_out("snap.en_off", 4'b1111, 7'b1111111, 1'b1, 1'b0);
        en = 1'b1;
      end
      if (j == 14) check_out("snap.en_on", 4'b1101, 7'b0110000, 1'b1, 1'b0);
      if (j == 18) check_out("snap.s2", 4'b1011, 7'b0100100, 1'b1, 1'b0);
      if (j == 26) check_out("snap.s3", 4'b0111, 7'b1111001, 1'b1, 1'b0);
      if (j == 30) check("snap.fs_low", 16'(frame_start), 16'd0);
      if (j == 31) check("snap.fs_next", 16'(frame_start), 16'd1);
    end
    repeat (3) @(negedge clk);
    check_out("snap.nines", 4'b1110, 7'b0010000, 1'b1, 1'b0);

    // Reset during slot 2, then blink over six frames from the restart.
    digits = 16'h1234;
    wait_fs("mid");
    repeat (19) @(negedge clk);
    check_out("mid.pre", 4'b1011, 7'b0100100, 1'b1, 1'b0);
    rst = 1'b1;
    blink_mask = 4'b0001;
    @(negedge clk);
    check_out("mid.rst", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    check("mid.rst_fs", 16'(frame_start), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 192; g++) begin
      @(negedge clk);
      f = g / 32;
      jj = g % 32;
      if (g == 0) check_out("mid.restart_guard", 4'b1111, 7'b0, 1'b1, 1'b1);
      if (jj == 2) begin
        if (f == 0)
          check_out($sformatf("blink.f%0d", f), 4'b1110, 7'b1000000, 1'b1, 1'b0);
        else if (f == 2 || f == 3)
          check_out($sformatf("blink.f%0d", f), 4'b1111, 7'b1111111, 1'b1, 1'b0);
        else
          check_out($sformatf("blink.f%0d", f), 4'b1110, 7'b0011001, 1'b1, 1'b0);
      end
      if (f == 2 && jj == 10) check_out("blink.f2_other", 4'b1101, 7'b0110000, 1'b1, 1'b0);
      if (jj == 31) check($sformatf("blink.fs%0d", f), 16'(frame_start), 16'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter SCAN_DIV, default 100000: clk cycles per digit slot; legal range is 4 or more.
REQ-002 Parameter GUARD, default 16: anode-off cycles at the start of each slot (anti-ghosting); legal range is 0 to SCAN_DIV-1.
REQ-003 Parameter BLINK_FRAMES, default 125: full scan frames per blink half-period; legal range is 1 or more.
REQ-004 Port clk, input, 1: clock; all logic SHALL be on its rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port en, input, 1: display enable; 0 blanks all outputs.
REQ-007 Port digits, input, 16: {d3,d2,d1,d0}, 4-bit value each; d0 is the rightmost digit.
REQ-008 Port dp_mask, input, 4: bit k lights the decimal point of digit k.
REQ-009 Port blink_mask, input, 4: bit k makes digit k blink.
REQ-010 Port lz_blank, input, 1: enables leading-zero blanking.
REQ-011 Port an, output, 4: active-low anodes; bit k drives digit k.
REQ-012 Port seg, output, 7: active-low segments, ordered {g,f,e,d,c,b,a}.
REQ-013 Port dp, output, 1: active-low decimal point.
REQ-014 Port frame_start, output, 1: one-cycle pulse at each frame boundary.

Function
REQ-015 A divider SHALL count 0..SCAN_DIV-1 and wrap; the cycle in which it wraps advances slot 0->1->2->3->0.
REQ-016 When slot wraps from 3 to 0, the block SHALL snapshot digits, dp_mask, blink_mask and lz_blank, and SHALL assert frame_start for exactly that cycle.
REQ-017 Input changes SHALL affect the display only through the snapshot; there is no mid-frame tearing.
REQ-018 an, seg and dp SHALL be registered, with 1 cycle latency from the slot/divider state.
REQ-019 While the divider count is below GUARD, an SHALL be 4'b1111.
REQ-020 Outside the guard window, an SHALL be the one-cold select of the current slot, unless that digit is blanked.
REQ-021 Values 0-9 SHALL decode as decimal glyphs and values 10-15 as hex glyphs A,b,C,d,E,F.
REQ-022 Leading-zero blanking, when enabled in the snapshot:
- d3 is blanked if it is 0.
- d2 is blanked if d3 and d2 are both 0.
- d1 is blanked if d3, d2 and d1 are all 0.
- d0 is never blanked.
REQ-023 A frame counter SHALL count completed frames; at BLINK_FRAMES-1 it wraps and toggles blink_phase.
REQ-024 While blink_phase is 1, digits whose snapshot blink_mask bit is set SHALL be blanked.
REQ-025 A blanked digit SHALL drive an bit 1, seg 7'b1111111 and dp 1.
REQ-026 dp SHALL be low exactly when the slot's dp_mask bit is set and the digit is lit; this includes digits blanked by leading-zero blanking staying dark.
REQ-027 When en is 0, outputs SHALL be an=4'b1111, seg=7'b1111111, dp=1.
- Counters, the snapshot and frame_start SHALL keep running.
- Re-enabling SHALL take effect within 1 cycle.

Reset
REQ-028 When rst is asserted, the block SHALL clear divider, slot, frame counter, blink_phase and snapshot to 0.
REQ-029 On the next edge after rst, outputs SHALL be an=4'b1111, seg=7'b1111111, dp=1 and frame_start=0.
REQ-030 rst asserted mid-slot or mid-frame SHALL abort the scan; after release, scanning SHALL restart at slot 0, divider 0.
REQ-031 The first frame after reset SHALL show the zero snapshot; the first frame_start SHALL occur 4*SCAN_DIV cycles after rst is released.

Structure
REQ-032 Package seg_pkg SHALL hold:
- the 16-entry glyph table;
- the SEG_BLANK constant (7'b1111111);
- the default parameter values.
REQ-033 Sub-module seg_hex_decode SHALL perform the 4-bit to 7-bit combinational decode.
REQ-034 seg_scan_display SHALL instantiate seg_hex_decode once.

Verification
Scenarios use SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2.
REQ-035 Reset: hold rst high for 3 cycles, then observe -> an=1111, seg=1111111, dp=1, frame_start=0; first frame_start 32 cycles after release.
REQ-036 Decode: digits=16'h1234, en=1, after one frame_start -> slot0 shows an=1110, seg=0011001; slot3 shows an=0111, seg=1111001; an=1111 for the first 2 cycles of each slot.
REQ-037 Snapshot: change digits from 16'h1234 to 16'h9999 during slot 1 -> slots 1-3 still show 3,2,1; 9s appear only after the next frame_start.
REQ-038 Blanking: digits=16'h0005, lz_blank=1, dp_mask=0010 -> only an=1110 is ever asserted, seg=0010010; dp stays 1 throughout.
REQ-039 Blink: blink_mask=0001 -> an[0] asserts in frames 0-1, stays high in frames 2-3, asserts again in frames 4-5.
REQ-040 Reset mid-operation: assert rst during slot 2 -> outputs are blank the next cycle; after release, slot 0 restarts with the zero snapshot (seg=1000000 for d0=0).
